inst_cache: RTL

Direct-mapped, read-only instruction cache between the CPU fetch stage and the instruction memory. It sits on the initiator side of the instruction-memory port: it drives `mem_address` and consumes the returned 32-bit word. On a hit it returns the instruction combinationally. On a miss it stalls fetch and refills one full line, one word per cycle, from the combinational instruction memory.

---
 rtl/inst_cache.sv | 130 +++++++++++++
 1 files changed

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. Hits return combinationally;
// a miss stalls fetch while a whole line is refilled one word per cycle.
module inst_cache #(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  input  logic        pc_valid,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        stall,
  output logic [63:0] mem_address,
  input  logic [31:0] mem_instruction,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int W     = $clog2(WORDS_PER_LINE);
  localparam int I     = $clog2(LINES);
  localparam int TAG_W = 64 - W - I - 2;

  localparam logic [0:0]   IDLE      = 1'b0;
  localparam logic [0:0]   REFILL    = 1'b1;
  localparam logic [W-1:0] LAST_WORD = W'(WORDS_PER_LINE - 1);

  logic [0:0]       state_r;
  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES][WORDS_PER_LINE];
  logic [63:0]      base_r;
  logic [W-1:0]     refill_cnt_r;
  logic [31:0]      hit_count_r;
  logic [31:0]      miss_count_r;

  logic [W-1:0]     word_sel_s;
  logic [I-1:0]     index_s;
  logic [TAG_W-1:0] tag_s;
  logic [I-1:0]     ref_idx_s;
  logic [TAG_W-1:0] ref_tag_s;
  logic             hit_s;
  logic             unused_s;

  assign word_sel_s = pc[W+1:2];
  assign index_s    = pc[W+I+1:W+2];
  assign tag_s      = pc[63:W+I+2];
  assign ref_idx_s  = base_r[W+I+1:W+2];
  assign ref_tag_s  = base_r[63:W+I+2];
  assign unused_s   = ^pc[1:0];

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

  // Lookup and fetch-side outputs
  always_comb begin
    hit_s       = 1'b0;
    instruction = 32'd0;
    stall       = 1'b0;
    mem_address = 64'd0;
    case (state_r)
      IDLE: begin
        hit_s = pc_valid & valid_r[index_s] & (tag_r[index_s] == tag_s);
        if (hit_s) begin
          instruction = data_r[index_s][word_sel_s];
        end else begin
          instruction = 32'd0;
        end
        stall = pc_valid & ~hit_s;
      end
      REFILL: begin
        stall       = 1'b1;
        mem_address = base_r + {{(62-W){1'b0}}, refill_cnt_r, 2'b00};
      end
      default: begin
        stall = 1'b1;
      end
    endcase
  end

  // Control state, valid bits and counters; flush overrides any valid set
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      valid_r      <= {LINES{1'b0}};
      refill_cnt_r <= {W{1'b0}};
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hit_s) begin
            hit_count_r <= hit_count_r + 32'd1;
          end else if (pc_valid) begin
            base_r           <= {pc[63:W+2], {(W+2){1'b0}}};
            refill_cnt_r     <= {W{1'b0}};
            miss_count_r     <= miss_count_r + 32'd1;
            valid_r[index_s] <= 1'b0;
            state_r          <= REFILL;
          end
        end
        REFILL: begin
          refill_cnt_r <= refill_cnt_r + {{(W-1){1'b0}}, 1'b1};
          if (refill_cnt_r == LAST_WORD) begin
            valid_r[ref_idx_s] <= 1'b1;
            state_r            <= IDLE;
          end
          if (flush) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (flush) begin
        valid_r <= {LINES{1'b0}};
      end
    end
  end

  // Line data and tag storage, written while refilling
  always_ff @(posedge clk) begin
    if (!reset && state_r == REFILL) begin
      data_r[ref_idx_s][refill_cnt_r] <= mem_instruction;
      if (refill_cnt_r == LAST_WORD) begin
        tag_r[ref_idx_s] <= ref_tag_s;
      end
    end
  end

endmodule
